// File: rtl/fft_loader.sv
// FFT front end: windows a real sample stream, scales it and writes
// one bit-reversed complex frame into the FFT RAM, then starts the FFT.

module hann_lut #(
    parameter int width = 16,
    parameter int N_2   = 11
) (
    input  logic [N_2-1:0]   idx,
    output logic [width-1:0] coef
);
    localparam int N = 1 << N_2;

    // sin^2(pi*n/N) via Bhaskara's sine form; exact 0 at n=0 and 1 at N/2
    function automatic logic [width-1:0] hann_coef(input int n);
        longint nn, p, s, h, lim;
        nn  = longint'(N);
        p   = longint'(n) * (nn - longint'(n));
        s   = ((p * 16) << width) / (nn * nn * 5 - p * 4);
        h   = (s * s) >> width;
        lim = (longint'(1) << width) - 1;
        if (h > lim) h = lim;
        return h[width-1:0];
    endfunction

    logic [width-1:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic [width-1:0] C = hann_coef(i);
        assign rom[i] = C;
    end

    assign coef = rom[idx];
endmodule

module fft_loader #(
    parameter int width  = 16,
    parameter int N_2    = 11,
    parameter int GUARD  = 5,
    parameter int BITREV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 we,
    output logic [N_2-1:0]       adr,
    output logic [2*width-1:0]   wd,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 busy
);
    typedef enum logic [1:0] {
        LOAD,
        DRAIN,
        START,
        BUSY
    } state_t;

    state_t state, state_n;

    logic [N_2-1:0]          idx;
    logic [N_2-1:0]          idx1;
    logic                    v1;
    logic signed [width-1:0] samp1;
    logic [width-1:0]        coef;
    logic [width-1:0]        coef1;
    logic signed [2*width:0] prod;
    logic signed [2*width:0] prod_sh;
    logic [width-1:0]        re;
    logic                    accept;

    function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] a);
        logic [N_2-1:0] r;
        for (int k = 0; k < N_2; k++) r[k] = a[N_2-1-k];
        return r;
    endfunction

    hann_lut #(
        .width(width),
        .N_2  (N_2)
    ) u_lut (
        .idx (idx),
        .coef(coef)
    );

    assign in_ready  = (state == LOAD) && !reset;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != LOAD);
    assign fft_start = (state == START);

    // coef is unsigned, so it gets a zero sign bit before the signed multiply
    assign prod    = samp1 * $signed({1'b0, coef1});
    assign prod_sh = prod >>> (width + GUARD);
    assign re      = prod_sh[width-1:0];

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (accept && (idx == '1)) state_n = DRAIN;
            // stage 1 empty means the last write is on the RAM port now
            DRAIN:   if (!v1) state_n = START;
            START:   state_n = BUSY;
            BUSY:    if (fft_done) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            idx   <= '0;
        end else begin
            state <= state_n;
            if (accept)
                idx <= idx + 1'b1;
            else if ((state == BUSY) && fft_done)
                idx <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            samp1 <= '0;
            coef1 <= '0;
            idx1  <= '0;
            we    <= 1'b0;
            adr   <= '0;
            wd    <= '0;
        end else begin
            v1 <= accept;
            we <= v1;
            if (accept) begin
                samp1 <= in_data;
                coef1 <= coef;
                idx1  <= idx;
            end
            if (v1) begin
                adr <= (BITREV != 0) ? bitrev(idx1) : idx1;
                wd  <= {re, {width{1'b0}}};
            end
        end
    end
endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: reset, pipeline timing, arithmetic,
// full and gappy frames, FFT handshake and mid-frame reset.

module tb_fft_loader;
    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [10:0] adr;
    logic [31:0] wd;
    logic        fft_start;
    logic        fft_done;
    logic        busy;

    int n_chk;
    int n_fail;

    logic        clr;
    int          wcount;
    int          starts;
    int          hits [2048];
    logic [31:0] mem  [2048];

    fft_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .adr      (adr),
        .wd       (wd),
        .fft_start(fft_start),
        .fft_done (fft_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr) begin
            wcount = 0;
            starts = 0;
            for (int i = 0; i < 2048; i++) begin
                hits[i] = 0;
                mem[i]  = '0;
            end
        end else begin
            if (we) begin
                wcount++;
                hits[adr]++;
                mem[adr] = wd;
            end
            if (fft_start) starts++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int cov_errors();
        int bad;
        bad = 0;
        for (int i = 0; i < 2048; i++)
            if (hits[i] != 1) bad++;
        return bad;
    endfunction

    initial begin
        int acc;
        int cyc;
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        fft_done = 1'b0;
        clr      = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_start", 64'(fft_start), 64'(0));
        chk("rst_adr", 64'(adr), 64'(0));
        chk("rst_wd", 64'(wd), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // frame 1: back-to-back 0x7FFF
        reset = 1'b0;
        #1;
        chk("rel_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 2048; i++) begin
            if (i == 1) chk("lat_we0", 64'(we), 64'(0));
            if (i == 2) begin
                chk("i0_we", 64'(we), 64'(1));
                chk("i0_adr", 64'(adr), 64'(0));
                chk("i0_wd", 64'(wd), 64'(0));
            end
            if (i == 3) begin
                chk("i1_adr", 64'(adr), 64'(11'h400));
                chk("i1_im", 64'(wd[15:0]), 64'(0));
            end
            if (i == 4) chk("i2_adr", 64'(adr), 64'(11'h200));
            tick();
        end
        chk("f1_ready_drop", 64'(in_ready), 64'(0));
        chk("f1_busy", 64'(busy), 64'(1));
        tick();
        chk("f1_last_we", 64'(we), 64'(1));
        chk("f1_last_adr", 64'(adr), 64'(11'h7FF));
        chk("f1_no_start", 64'(fft_start), 64'(0));
        tick();
        chk("f1_start", 64'(fft_start), 64'(1));
        chk("f1_we_off", 64'(we), 64'(0));
        tick();
        chk("f1_start_1cy", 64'(fft_start), 64'(0));
        for (int k = 0; k < 5; k++) tick();
        chk("f1_hold_busy", 64'(busy), 64'(1));
        chk("f1_hold_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("f1_ready_back", 64'(in_ready), 64'(1));
        chk("f1_busy_off", 64'(busy), 64'(0));
        chk("f1_writes", 64'(wcount), 64'(2048));
        chk("f1_starts", 64'(starts), 64'(1));
        chk("f1_cov", 64'(cov_errors()), 64'(0));
        chk("f1_wd_mid", 64'(mem[1]), 64'(32'h03FF0000));
        chk("f1_wd_zero", 64'(mem[0]), 64'(0));

        // frame 2: valid every other cycle, stray fft_done
        clr = 1'b1;
        tick();
        clr = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 2048 && cyc < 8000) begin
            in_valid = (cyc % 2) == 0;
            in_data  = (acc == 1024) ? 16'h8000 : 16'h1234;
            fft_done = (cyc == 101);
            if (cyc == 102) begin
                chk("f2_done_ign_busy", 64'(busy), 64'(0));
                chk("f2_done_ign_rdy", 64'(in_ready), 64'(1));
            end
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        fft_done = 1'b0;
        chk("f2_accepts", 64'(acc), 64'(2048));
        for (int k = 0; k < 20; k++) begin
            if (fft_start) break;
            tick();
        end
        chk("f2_start", 64'(fft_start), 64'(1));
        tick();
        tick();
        chk("f2_busy", 64'(busy), 64'(1));
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("f2_ready_back", 64'(in_ready), 64'(1));
        chk("f2_writes", 64'(wcount), 64'(2048));
        chk("f2_starts", 64'(starts), 64'(1));
        chk("f2_cov", 64'(cov_errors()), 64'(0));
        chk("f2_wd_neg", 64'(mem[1]), 64'(32'hFC000000));

        // frame 3: reset after 700 samples
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_data = 16'h0100;
        for (int i = 0; i < 700; i++) begin
            in_valid = 1'b1;
            tick();
        end
        chk("f3_inflight", 64'(we), 64'(1));
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("f3_squash", 64'(we), 64'(0));
        chk("f3_busy", 64'(busy), 64'(0));
        tick();
        tick();
        chk("f3_no_start", 64'(fft_start), 64'(0));
        chk("f3_starts", 64'(starts), 64'(0));
        reset    = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("f3_re_we", 64'(we), 64'(1));
        chk("f3_re_adr", 64'(adr), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_loader.md
Name: fft_loader

Overview:
- Front end that fills the FFT working RAM with one N-point frame and launches the transform.
- Accepts a stream of real signed samples over a valid/ready handshake and applies the Hann window via the shared hann_lut.
- Scales each sample for FFT bit-growth headroom and writes it as a packed complex word {re, im=0} at the bit-reversed address.
- After N writes, pulses fft_start and holds off new input until the FFT reports done.

Parameters:
- width, 16: real/imag component width of the packed complex RAM word (2*width bits total).
- N_2, 11: log2 of the FFT length N; N = 2**N_2 = 2048 by default.
- GUARD, 5: extra right-shift headroom bits applied after windowing.
- BITREV, 1: 1 = write address is bit-reversed idx; 0 = natural order.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  width  signed real input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a sample this cycle.
- we  out  1  RAM write enable.
- adr  out  N_2  RAM write address.
- wd  out  2*width  RAM write data {re[width-1:0], im[width-1:0]}.
- fft_start  out  1  one-cycle pulse that launches the FFT.
- fft_done  in  1  FFT completion; sampled only in BUSY.
- busy  out  1  high from last sample accepted until fft_done is seen.

Behaviour:
- Reset (async, active-high):
  - state=LOAD; idx=0; pipeline valids cleared.
  - Outputs: we=0, adr=0, wd=0, fft_start=0, busy=0.
  - in_ready asserts after reset deasserts.
- Accept condition: in_valid & in_ready. Accept at cycle t with index idx.
- Pipeline timing:
  - t: hann_lut idx driven.
  - t+1: coefficient and registered sample available; multiply result registered.
  - t+2: we=1, adr=BITREV ? bitrev(idx) : idx, wd={re,0}.
- Latency from accept to write is exactly 2 cycles. Fully pipelined, so one sample per cycle is sustained.
- Arithmetic:
  - coef is unsigned Q0.width.
  - The product is sample (signed) * {1'b0,coef}, computed at 2*width+1 bits.
  - re = product >>> (width+GUARD), truncated toward -inf, taken as the low width bits. The result always fits.
  - im = 0.
- States:
  - LOAD: in_ready=1. Each accept increments idx. Accepting idx=N-1 moves to DRAIN with in_ready=0 in the next cycle.
  - DRAIN: waits until both pipeline stages are empty (last write issued), then moves to START.
  - START: fft_start=1 for exactly one cycle, then moves to BUSY. fft_done is ignored here.
  - BUSY: in_ready=0, busy=1. When fft_done=1, moves to LOAD with idx=0; in_ready=1 the next cycle.
- busy is 1 in DRAIN, START and BUSY.
- idx wraps from N-1 to 0 only through the BUSY→LOAD transition; it never free-runs.
- When in_valid=0 in LOAD: nothing is accepted, idx holds, and we=0 in the corresponding write cycle. Bubbles propagate.
- fft_done asserted outside BUSY has no effect.
- Reset mid-frame: a partial frame is discarded, no fft_start is issued, in-flight writes are squashed (we=0), and the next frame restarts at idx=0.

Test Plan:
- Reset with in_valid=1 held → in_ready=1 after reset release, we=0 and fft_start=0 during reset; first accept produces we=1 exactly 2 cycles later at adr=0.
- Stream idx 0..2 with in_data=0x7FFF → writes at adr 0x000, 0x400, 0x200 with im=0; idx 0 gives wd=0x00000000 (coef 0).
- At idx 1024, in_data=0x7FFF, coef=0xFFFF → wd re = 32767*65535>>21 = 0x03FF, im=0x0000; in_data=0x8000 with the same coef → re=0xFC00.
- Full frame of 2048 back-to-back samples:
  - in_ready drops the cycle after the 2048th accept.
  - Last write at adr 0x7FF.
  - fft_start pulses once, one cycle after that write.
  - busy stays high until fft_done=1.
  - in_ready=1 the cycle after fft_done.
- Gappy input (in_valid toggling 1/0) → exactly 2048 writes, no duplicates; addresses cover 0..2047 once each; fft_done pulsed during LOAD is ignored.
- Assert reset at idx=700 → we=0 immediately, no fft_start; the next accepted sample writes adr 0.
